// File: rtl/uart_pkg.sv
// Shared UART receive definitions: baud code, FSM state encoding and the
// divisor computation that turns CLK_HZ into a 16x-oversampling tick period.
package uart_pkg;

    typedef enum logic [1:0] {
        BAUD_2400  = 2'b00,
        BAUD_4800  = 2'b01,
        BAUD_9600  = 2'b10,
        BAUD_19200 = 2'b11
    } baud_code_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    function automatic int baud_hz(baud_code_t code);
        case (code)
            BAUD_4800:  return 4800;
            BAUD_9600:  return 9600;
            BAUD_19200: return 19200;
            default:    return 2400;
        endcase
    endfunction

    // Rounded to nearest: (clk + den/2) / den
    function automatic int baud_div(int clk_hz, int os, baud_code_t code);
        int den;
        den = os * baud_hz(code);
        return (clk_hz + den / 2) / den;
    endfunction

endpackage

// File: rtl/baud_gen_rx.sv
// Oversampling tick generator: one-cycle tick every `divisor` clocks,
// restartable by a synchronous clear so ticks align to the start edge.
module baud_gen_rx #(
    parameter int DIV_W = 11
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // >= keeps the counter from running away if the divisor ever shrinks
    assign tick = (cnt >= divisor - DIV_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_unit.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 framing
// with an added parity_error pulse alongside data_valid.
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [1:0]           baud_rate,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_error
`endif
);

    localparam int DIV_2400  = baud_div(CLK_HZ, OVERSAMPLE, BAUD_2400);
    localparam int DIV_4800  = baud_div(CLK_HZ, OVERSAMPLE, BAUD_4800);
    localparam int DIV_9600  = baud_div(CLK_HZ, OVERSAMPLE, BAUD_9600);
    localparam int DIV_19200 = baud_div(CLK_HZ, OVERSAMPLE, BAUD_19200);
    localparam int DIV_W     = $clog2(DIV_2400 + 1);
    localparam int OS_W      = $clog2(OVERSAMPLE);
    localparam int BIT_W     = $clog2(DATA_BITS);

    logic                 rx_sync_p0, rx_sync_p1, rx_prev_p2;
    logic                 fall_edge;
    logic [2:0]           state;
    baud_code_t           baud_lat;
    logic [DIV_W-1:0]     div_sel;
    logic                 start_det;
    logic                 tick;
    logic [OS_W-1:0]      tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 mid_start, mid_bit;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad;
`endif

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_prev_p2 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx_serial;
            rx_sync_p1 <= rx_sync_p0;
            rx_prev_p2 <= rx_sync_p1;
        end
    end

    assign fall_edge = rx_prev_p2 & ~rx_sync_p1;
    assign start_det = (state == ST_IDLE) && fall_edge;
    assign mid_start = tick && (tick_cnt == OS_W'(OVERSAMPLE / 2 - 1));
    assign mid_bit   = tick && (tick_cnt == OS_W'(OVERSAMPLE - 1));
    assign busy      = (state == ST_DATA) || (state == ST_PARITY) ||
                       (state == ST_STOP) || (state == ST_BREAK);

    always_comb begin
        div_sel = DIV_W'(DIV_9600);
        case (baud_lat)
            BAUD_2400:  div_sel = DIV_W'(DIV_2400);
            BAUD_4800:  div_sel = DIV_W'(DIV_4800);
            BAUD_9600:  div_sel = DIV_W'(DIV_9600);
            BAUD_19200: div_sel = DIV_W'(DIV_19200);
            default:    div_sel = DIV_W'(DIV_9600);
        endcase
    end

    baud_gen_rx #(
        .DIV_W   (DIV_W)
    ) u_baud_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (start_det),
        .divisor (div_sel),
        .tick    (tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            baud_lat    <= BAUD_9600;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error <= 1'b0;
`endif
            if (tick) begin
                tick_cnt <= tick_cnt + OS_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (fall_edge) begin
                        state    <= ST_START;
                        baud_lat <= baud_code_t'(baud_rate);
                        tick_cnt <= '0;
                    end
                end
                ST_START: begin
                    // A line back high at mid-start is a glitch, not a frame
                    if (mid_start) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_sync_p1 ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mid_bit) begin
                        tick_cnt  <= '0;
                        shift_reg <= {rx_sync_p1, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (mid_bit) begin
                        tick_cnt   <= '0;
                        parity_bad <= (^shift_reg) ^ rx_sync_p1;
                        state      <= ST_STOP;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                ST_STOP: begin
                    if (mid_bit) begin
                        tick_cnt <= '0;
                        data_out <= shift_reg;
                        if (rx_sync_p1) begin
                            data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_error <= parity_bad;
`endif
                            state <= ST_IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_sync_p1) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit at a scaled clock (divisors 32/16/8/4),
// covering 8N1 and, with UART_RX_PARITY_EN, 8E1 framing.
module tb_uart_rx_unit;

    localparam int CLK_HZ = 1_228_800;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] baud_rate;
    logic       rx_serial;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    uart_rx_unit #(
        .CLK_HZ      (CLK_HZ),
        .OVERSAMPLE  (16),
        .DATA_BITS   (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .baud_rate   (baud_rate),
        .rx_serial   (rx_serial),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .busy        (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error(parity_error)
`endif
    );

    always #5 clock = ~clock;

    int div_of [4] = '{32, 16, 8, 4};

    int n_chk  = 0;
    int n_pass = 0;

    int         cyc = 0;
    int         vld_cnt = 0, ferr_cnt = 0, both_cnt = 0, busy_cyc = 0;
    int         last_vld_cyc = 0;
    logic [7:0] last_byte = 8'h00, prev_byte = 8'h00;
`ifdef UART_RX_PARITY_EN
    int         perr_cnt = 0, perr_nv = 0;
`endif

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (data_valid) begin
            vld_cnt      <= vld_cnt + 1;
            prev_byte    <= last_byte;
            last_byte    <= data_out;
            last_vld_cyc <= cyc;
        end
        if (frame_error) ferr_cnt <= ferr_cnt + 1;
        if (data_valid && frame_error) both_cnt <= both_cnt + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_error) perr_cnt <= perr_cnt + 1;
        if (parity_error && !data_valid) perr_nv <= perr_nv + 1;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives one frame with bench-side bit timing; stop level and parity fault selectable
    task automatic send_frame(input logic [7:0] b, input int d, input logic stop_lvl,
                              input logic bad_par);
        int bp;
        bp = 16 * d;
        rx_serial = 1'b0;
        wait_cyc(bp);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            wait_cyc(bp);
        end
`ifdef UART_RX_PARITY_EN
        rx_serial = (^b) ^ bad_par;
        wait_cyc(bp);
`else
        if (bad_par) rx_serial = 1'b1;
`endif
        rx_serial = stop_lvl;
        wait_cyc(bp);
    endtask

    int v0, f0, b0, st, lat, lo, hi;
`ifdef UART_RX_PARITY_EN
    int p0;
`endif

    initial begin
        reset_n   = 1'b0;
        rx_serial = 1'b1;
        baud_rate = 2'b10;
        wait_cyc(3);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_frame_error", 32'(frame_error), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        wait_cyc(5);

        // 1: 0xA5 at 9600, latency from start edge to data_valid
        v0 = vld_cnt; f0 = ferr_cnt;
        st = cyc;
        send_frame(8'hA5, 8, 1'b1, 1'b0);
        wait_cyc(4);
        lat = last_vld_cyc - st;
        lo  = (FRAME_BITS * 16 - 8) * 8;
        hi  = lo + 6;
        chk("t1_vld_count", 32'(vld_cnt - v0), 32'd1);
        chk("t1_data", 32'(last_byte), 32'hA5);
        chk("t1_latency_ok", 32'(lat >= lo && lat <= hi), 32'd1);
        chk("t1_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // 2: 0x00 then 0xFF back to back at every rate
        for (int r = 0; r < 4; r++) begin
            baud_rate = 2'(r);
            wait_cyc(16);
            v0 = vld_cnt; f0 = ferr_cnt;
            send_frame(8'h00, div_of[r], 1'b1, 1'b0);
            send_frame(8'hFF, div_of[r], 1'b1, 1'b0);
            wait_cyc(4);
            chk($sformatf("t2_r%0d_vld_count", r), 32'(vld_cnt - v0), 32'd2);
            chk($sformatf("t2_r%0d_first", r), 32'(prev_byte), 32'h00);
            chk($sformatf("t2_r%0d_second", r), 32'(last_byte), 32'hFF);
            chk($sformatf("t2_r%0d_no_ferr", r), 32'(ferr_cnt - f0), 32'd0);
        end

        // 3: short low glitch on idle line at 9600
        baud_rate = 2'b10;
        wait_cyc(16);
        v0 = vld_cnt; f0 = ferr_cnt; b0 = busy_cyc;
        rx_serial = 1'b0;
        wait_cyc(3);
        rx_serial = 1'b1;
        wait_cyc(3 * 128);
        chk("t3_no_vld", 32'(vld_cnt - v0), 32'd0);
        chk("t3_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("t3_never_busy", 32'(busy_cyc - b0), 32'd0);
        chk("t3_busy_low", 32'(busy), 32'd0);

        // 4: stop bit low, line held low two bit times, then a good 0x55
        v0 = vld_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 8, 1'b0, 1'b0);
        wait_cyc(128);
        chk("t4_busy_in_break", 32'(busy), 32'd1);
        rx_serial = 1'b1;
        wait_cyc(128);
        chk("t4_ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
        chk("t4_no_vld", 32'(vld_cnt - v0), 32'd0);
        chk("t4_busy_cleared", 32'(busy), 32'd0);
        v0 = vld_cnt;
        send_frame(8'h55, 8, 1'b1, 1'b0);
        wait_cyc(4);
        chk("t4_next_vld", 32'(vld_cnt - v0), 32'd1);
        chk("t4_next_data", 32'(last_byte), 32'h55);

        // 5: reset during bit 4 of 0x81, then a clean 0x81
        v0 = vld_cnt;
        rx_serial = 1'b0;
        wait_cyc(128);
        for (int i = 0; i < 4; i++) begin
            rx_serial = (i == 0);
            wait_cyc(128);
        end
        rx_serial = 1'b0;
        wait_cyc(20);
        reset_n = 1'b0;
        wait_cyc(2);
        chk("t5_rst_data_out", 32'(data_out), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_valid", 32'(data_valid), 32'd0);
        chk("t5_rst_ferr", 32'(frame_error), 32'd0);
        rx_serial = 1'b1;
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(128);
        chk("t5_no_partial", 32'(vld_cnt - v0), 32'd0);
        send_frame(8'h81, 8, 1'b1, 1'b0);
        wait_cyc(4);
        chk("t5_vld", 32'(vld_cnt - v0), 32'd1);
        chk("t5_data", 32'(last_byte), 32'h81);

        // 6: baud change mid-frame only affects the following frame
        baud_rate = 2'b10;
        wait_cyc(16);
        v0 = vld_cnt;
        fork
            send_frame(8'hC3, 8, 1'b1, 1'b0);
            begin
                wait_cyc(4 * 128);
                baud_rate = 2'b11;
            end
        join
        wait_cyc(4);
        chk("t6_vld_9600", 32'(vld_cnt - v0), 32'd1);
        chk("t6_data_9600", 32'(last_byte), 32'hC3);
        wait_cyc(16);
        send_frame(8'h5A, 4, 1'b1, 1'b0);
        wait_cyc(4);
        chk("t6_vld_19200", 32'(vld_cnt - v0), 32'd2);
        chk("t6_data_19200", 32'(last_byte), 32'h5A);

`ifdef UART_RX_PARITY_EN
        chk("par_none_on_good", 32'(perr_cnt), 32'd0);
        baud_rate = 2'b10;
        wait_cyc(16);
        v0 = vld_cnt; p0 = perr_cnt;
        send_frame(8'h07, 8, 1'b1, 1'b1);
        wait_cyc(4);
        chk("par_vld", 32'(vld_cnt - v0), 32'd1);
        chk("par_err_pulse", 32'(perr_cnt - p0), 32'd1);
        chk("par_data", 32'(last_byte), 32'h07);
        chk("par_with_vld", 32'(perr_nv), 32'd0);
`endif

        chk("vld_ferr_exclusive", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
